// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory bus between instruction fetch and data ports, generating
// the pipeline stall signals and holding completed results until the pipeline advances.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imem_req,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    imem_wait,
  input  logic                    dmem_req,
  input  logic                    dmem_we,
  input  logic [DATA_WIDTH/8-1:0] dmem_be,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_wait,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic                    bus_ack,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    bus_error
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  typedef struct packed {
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } bus_cmd_t;

  logic [1:0]            state_q, state_d;
  bus_cmd_t              cmd_q, cmd_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_error_q, bus_error_d;
  logic                  i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DATA_WIDTH-1:0] i_hold_q, i_hold_d, d_hold_q, d_hold_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_i, pend_d, advance, tmo, d_own, start_i, start_d;

  assign pend_i    = imem_req & ~i_done_q;
  assign pend_d    = dmem_req & ~d_done_q;
  assign imem_wait = pend_i;
  assign dmem_wait = pend_d;
  assign advance   = ~pend_i & ~pend_d;
  assign d_own     = (state_q == D_BUSY);
  assign tmo       = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  assign imem_rdata = i_hold_q;
  assign dmem_rdata = d_hold_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = cmd_q.we;
  assign bus_be     = cmd_q.be;
  assign bus_addr   = cmd_q.addr;
  assign bus_wdata  = cmd_q.wdata;
  assign bus_error  = bus_error_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bus_req_d   = bus_req_q;
    bus_error_d = 1'b0;
    i_done_d    = i_done_q & ~advance;
    d_done_d    = d_done_q & ~advance;
    i_hold_d    = i_hold_q;
    d_hold_d    = d_hold_q;
    cnt_d       = cnt_q;
    start_i     = 1'b0;
    start_d     = 1'b0;
    case (state_q)
      IDLE: begin
        start_d = pend_d;
        start_i = pend_i & ~pend_d;
      end
      I_BUSY, D_BUSY: begin
        if (bus_ack || tmo) begin
          // A timeout completes the port with zero data; an ack may chain
          // straight into the other port's access.
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          cnt_d       = '0;
          bus_error_d = ~bus_ack;
          if (d_own) begin
            d_hold_d = bus_ack ? bus_rdata : '0;
            if (dmem_req) d_done_d = 1'b1;
            start_i  = bus_ack & pend_i;
          end else begin
            i_hold_d = bus_ack ? bus_rdata : '0;
            if (imem_req) i_done_d = 1'b1;
            start_d  = bus_ack & pend_d;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
    if (start_d) begin
      state_d     = D_BUSY;
      bus_req_d   = 1'b1;
      cmd_d.we    = dmem_we;
      cmd_d.be    = dmem_be;
      cmd_d.addr  = dmem_addr;
      cmd_d.wdata = dmem_wdata;
    end else if (start_i) begin
      state_d     = I_BUSY;
      bus_req_d   = 1'b1;
      cmd_d.we    = 1'b0;
      cmd_d.be    = '1;
      cmd_d.addr  = imem_addr;
      cmd_d.wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_error_q <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_hold_q    <= '0;
      d_hold_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bus_req_q   <= bus_req_d;
      bus_error_q <= bus_error_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_hold_q    <= i_hold_d;
      d_hold_q    <= d_hold_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule
